// File: rtl/dm_arb_pkg.sv
// Shared types and encodings for the data-memory port arbiter.
package dm_arb_pkg;

  typedef enum logic {
    ARB_CPU = 1'b0,
    ARB_DMA = 1'b1
  } arb_state_e;

  localparam logic OWN_C = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [3:0] WE_NONE = 4'b0000;
  localparam logic [3:0] WE_WORD = 4'b1111;

  function automatic logic is_read(input logic [3:0] we);
    return we == WE_NONE;
  endfunction

endpackage

// File: rtl/dm_arb_starve_ctr.sv
// Saturating DMA starvation counter and forced-burst length counter,
// with threshold flags consumed by the arbiter FSM.
module dm_arb_starve_ctr #(
  parameter int STARVE_MAX = 8,
  parameter int DMA_BURST  = 4,
  parameter int STARVE_W   = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1,
  parameter int BURST_W    = (DMA_BURST > 1) ? $clog2(DMA_BURST) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic starve_inc_i,
  input  logic burst_inc_i,
  input  logic burst_clr_i,
  output logic starve_at_max_o,
  output logic burst_last_o
);

  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [BURST_W-1:0]  burst_q, burst_d;

  assign starve_at_max_o = (starve_q == STARVE_W'(STARVE_MAX - 1));
  assign burst_last_o    = (burst_q == BURST_W'(DMA_BURST - 1));

  always_comb begin
    starve_d = '0;
    if (starve_inc_i) begin
      starve_d = starve_at_max_o ? starve_q : starve_q + 1'b1;
    end
    burst_d = burst_q;
    if (burst_clr_i) begin
      burst_d = '0;
    end else if (burst_inc_i) begin
      burst_d = burst_last_o ? '0 : burst_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      burst_q  <= '0;
    end else begin
      starve_q <= starve_d;
      burst_q  <= burst_d;
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Two-port (CPU / debug DMA) arbiter for the single-port byte-lane data memory.
// Optional ARB_PERF_EN adds stall / grant / forced-transition counters.
//
// state   | meaning
// ARB_CPU | CPU has priority; refused DMA cycles build starvation credit
// ARB_DMA | forced DMA burst; CPU only gets the port if DMA idles
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8,
  parameter int DMA_BURST  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic [3:0]        c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_stall,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_cs,
  output logic [3:0]        m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]       perf_c_stall,
  output logic [31:0]       perf_d_grant,
  output logic [15:0]       perf_forced
`endif
);

  arb_state_e state_q;
  logic       rd_owner_q;
  logic       c_rvalid_q, d_rvalid_q;

  logic starve_inc, starve_at_max, burst_inc, burst_clr, burst_last;
  logic force_dma, leave_dma;

  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (state_q == ARB_CPU) begin
      c_gnt = c_req;
      d_gnt = d_req & ~c_req;
    end else begin
      d_gnt = d_req;
      c_gnt = c_req & ~d_req;
    end

    m_we    = WE_NONE;
    m_addr  = '0;
    m_wdata = '0;
    if (c_gnt) begin
      m_we    = c_we;
      m_addr  = c_addr;
      m_wdata = c_wdata;
    end else if (d_gnt) begin
      m_we    = d_we;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end
  end

  assign m_cs    = c_gnt | d_gnt;
  assign c_stall = c_req & ~c_gnt;

  // Starvation credit only accrues while the CPU holds priority.
  assign starve_inc = (state_q == ARB_CPU) & d_req & ~d_gnt;
  assign force_dma  = starve_inc & starve_at_max;
  assign burst_inc  = (state_q == ARB_DMA) & d_gnt;
  assign burst_clr  = (state_q == ARB_CPU);
  assign leave_dma  = ~d_req | (d_gnt & burst_last);

  dm_arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX),
    .DMA_BURST  (DMA_BURST)
  ) u_ctr (
    .clk             (clk),
    .rst             (rst),
    .starve_inc_i    (starve_inc),
    .burst_inc_i     (burst_inc),
    .burst_clr_i     (burst_clr),
    .starve_at_max_o (starve_at_max),
    .burst_last_o    (burst_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_CPU;
      rd_owner_q <= OWN_C;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
    end else begin
      case (state_q)
        ARB_CPU: if (force_dma) state_q <= ARB_DMA;
        ARB_DMA: if (leave_dma) state_q <= ARB_CPU;
        default: state_q <= ARB_CPU;
      endcase
      if (m_cs && is_read(m_we)) begin
        rd_owner_q <= d_gnt ? OWN_D : OWN_C;
      end
      c_rvalid_q <= c_gnt & is_read(c_we);
      d_rvalid_q <= d_gnt & is_read(d_we);
    end
  end

  assign c_rvalid = c_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign c_rdata  = (c_rvalid_q && rd_owner_q == OWN_C) ? m_rdata : '0;
  assign d_rdata  = (d_rvalid_q && rd_owner_q == OWN_D) ? m_rdata : '0;

`ifdef ARB_PERF_EN
  logic [31:0] perf_c_stall_q, perf_d_grant_q;
  logic [15:0] perf_forced_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_c_stall_q <= '0;
      perf_d_grant_q <= '0;
      perf_forced_q  <= '0;
    end else begin
      if (c_stall)   perf_c_stall_q <= perf_c_stall_q + 1'b1;
      if (d_gnt)     perf_d_grant_q <= perf_d_grant_q + 1'b1;
      if (force_dma) perf_forced_q  <= perf_forced_q + 1'b1;
    end
  end

  assign perf_c_stall = perf_c_stall_q;
  assign perf_d_grant = perf_d_grant_q;
  assign perf_forced  = perf_forced_q;
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed, table-driven bench for dm_port_arbiter with a behavioural byte-lane memory.
module tb_dm_port_arbiter;
  import dm_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, d_req;
  logic [3:0]  c_we, d_we;
  logic [13:0] c_addr, d_addr;
  logic [31:0] c_wdata, d_wdata;
  logic        c_gnt, c_stall, c_rvalid, d_gnt, d_rvalid;
  logic [31:0] c_rdata, d_rdata;
  logic        m_cs;
  logic [3:0]  m_we;
  logic [13:0] m_addr;
  logic [31:0] m_wdata, m_rdata;
`ifdef ARB_PERF_EN
  logic [31:0] perf_c_stall, perf_d_grant;
  logic [15:0] perf_forced;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_port_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .c_req    (c_req),
    .c_we     (c_we),
    .c_addr   (c_addr),
    .c_wdata  (c_wdata),
    .c_gnt    (c_gnt),
    .c_stall  (c_stall),
    .c_rvalid (c_rvalid),
    .c_rdata  (c_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .m_cs     (m_cs),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata)
`ifdef ARB_PERF_EN
    ,
    .perf_c_stall (perf_c_stall),
    .perf_d_grant (perf_d_grant),
    .perf_forced  (perf_forced)
`endif
  );

  logic [31:0] mem [16384];

  always @(posedge clk) begin
    if (m_cs) begin
      if (m_we == 4'b0000) m_rdata <= mem[m_addr];
      for (int b = 0; b < 4; b++) begin
        if (m_we[b]) mem[m_addr][b*8 +: 8] <= m_wdata[b*8 +: 8];
      end
    end
  end

  typedef struct {
    logic        c_req;
    logic [3:0]  c_we;
    logic [13:0] c_addr;
    logic [31:0] c_wdata;
    logic        d_req;
    logic [3:0]  d_we;
    logic [13:0] d_addr;
    logic [31:0] d_wdata;
    logic        e_c_gnt;
    logic        e_d_gnt;
    logic [3:0]  e_m_we;
    logic [13:0] e_m_addr;
    logic [31:0] e_m_wdata;
    logic        e_c_rv;
    logic [31:0] e_c_rd;
    logic        e_d_rv;
    logic [31:0] e_d_rd;
    logic [2:0]  e_starve;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    c_req = 1'b0; c_we = 4'h0; c_addr = '0; c_wdata = '0;
    d_req = 1'b0; d_we = 4'h0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, nburst, stall_bad;

    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    mem[14'h2000] = 32'h12345678;
    mem[14'h2001] = 32'h11223344;
    mem[14'h3FFF] = 32'hFFFFFFFF;
    mem[14'h0010] = 32'hCAFEF00D;
    m_rdata = 32'h0;

    //            c_req c_we   c_addr    c_wdata       d_req d_we   d_addr    d_wdata       cg    dg    m_we   m_addr    m_wdata       crv   crd           drv   drd           starve
    vecs[0] = '{1'b1, 4'h0, 14'h2000, 32'hDEADBEEF, 1'b0, 4'h0, 14'h0000, 32'h0,        1'b1, 1'b0, 4'h0, 14'h2000, 32'hDEADBEEF, 1'b1, 32'h12345678, 1'b0, 32'h0,        3'd0};
    vecs[1] = '{1'b1, 4'h3, 14'h2001, 32'hAABBCCDD, 1'b0, 4'h0, 14'h0000, 32'h0,        1'b1, 1'b0, 4'h3, 14'h2001, 32'hAABBCCDD, 1'b0, 32'h0,        1'b0, 32'h0,        3'd0};
    vecs[2] = '{1'b1, 4'h0, 14'h2001, 32'h0,        1'b0, 4'h0, 14'h0000, 32'h0,        1'b1, 1'b0, 4'h0, 14'h2001, 32'h0,        1'b1, 32'h1122CCDD, 1'b0, 32'h0,        3'd0};
    vecs[3] = '{1'b0, 4'h0, 14'h0000, 32'h0,        1'b1, 4'h0, 14'h3FFF, 32'h0,        1'b0, 1'b1, 4'h0, 14'h3FFF, 32'h0,        1'b0, 32'h0,        1'b1, 32'hFFFFFFFF, 3'd0};
    vecs[4] = '{1'b1, 4'h0, 14'h0010, 32'h0,        1'b1, 4'hF, 14'h0030, 32'h01020304, 1'b1, 1'b0, 4'h0, 14'h0010, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0, 32'h0,        3'd1};
    vecs[5] = '{1'b0, 4'h0, 14'h0000, 32'h0,        1'b0, 4'h0, 14'h0000, 32'h0,        1'b0, 1'b0, 4'h0, 14'h0000, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        3'd0};
    vecs[6] = '{1'b0, 4'h0, 14'h0000, 32'h0,        1'b1, 4'hF, 14'h0020, 32'h55667788, 1'b0, 1'b1, 4'hF, 14'h0020, 32'h55667788, 1'b0, 32'h0,        1'b0, 32'h0,        3'd0};
    vecs[7] = '{1'b0, 4'h0, 14'h0000, 32'h0,        1'b1, 4'h0, 14'h0020, 32'h0,        1'b0, 1'b1, 4'h0, 14'h0020, 32'h0,        1'b0, 32'h0,        1'b1, 32'h55667788, 3'd0};
    vecs[8] = '{1'b1, 4'hC, 14'h0010, 32'h99AABBCC, 1'b0, 4'h0, 14'h0000, 32'h0,        1'b1, 1'b0, 4'hC, 14'h0010, 32'h99AABBCC, 1'b0, 32'h0,        1'b0, 32'h0,        3'd0};
    vecs[9] = '{1'b1, 4'h0, 14'h0010, 32'h0,        1'b0, 4'h0, 14'h0000, 32'h0,        1'b1, 1'b0, 4'h0, 14'h0010, 32'h0,        1'b1, 32'h99AAF00D, 1'b0, 32'h0,        3'd0};

    // Reset state
    do_reset();
    #1;
    chk("rst_c_rvalid", 32'(c_rvalid), 32'h0);
    chk("rst_d_rvalid", 32'(d_rvalid), 32'h0);
    chk("rst_state", 32'(dut.state_q), 32'(ARB_CPU));
    chk("rst_m_cs", 32'(m_cs), 32'h0);

    // Table-driven single-cycle transactions
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      c_req = vecs[i].c_req; c_we = vecs[i].c_we; c_addr = vecs[i].c_addr; c_wdata = vecs[i].c_wdata;
      d_req = vecs[i].d_req; d_we = vecs[i].d_we; d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
      #1;
      chk($sformatf("v%0d_c_gnt", i), 32'(c_gnt), 32'(vecs[i].e_c_gnt));
      chk($sformatf("v%0d_d_gnt", i), 32'(d_gnt), 32'(vecs[i].e_d_gnt));
      chk($sformatf("v%0d_m_cs", i), 32'(m_cs), 32'(vecs[i].e_c_gnt | vecs[i].e_d_gnt));
      chk($sformatf("v%0d_c_stall", i), 32'(c_stall), 32'(vecs[i].c_req & ~vecs[i].e_c_gnt));
      chk($sformatf("v%0d_m_we", i), 32'(m_we), 32'(vecs[i].e_m_we));
      chk($sformatf("v%0d_m_addr", i), 32'(m_addr), 32'(vecs[i].e_m_addr));
      chk($sformatf("v%0d_m_wdata", i), m_wdata, vecs[i].e_m_wdata);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_c_rvalid", i), 32'(c_rvalid), 32'(vecs[i].e_c_rv));
      chk($sformatf("v%0d_c_rdata", i), c_rdata, vecs[i].e_c_rd);
      chk($sformatf("v%0d_d_rvalid", i), 32'(d_rvalid), 32'(vecs[i].e_d_rv));
      chk($sformatf("v%0d_d_rdata", i), d_rdata, vecs[i].e_d_rd);
      chk($sformatf("v%0d_starve", i), 32'(dut.u_ctr.starve_q), 32'(vecs[i].e_starve));
      idle_inputs();
    end

    // Starvation: CPU hogs the port, DMA must break in after 8 refusals
    @(negedge clk);
    do_reset();
    c_req = 1'b1; c_we = 4'h0; c_addr = 14'h0010;
    d_req = 1'b1; d_we = 4'h0; d_addr = 14'h3FFF;
    first = -1;
    for (int i = 0; i < 40 && first < 0; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (d_gnt) first = i;
    end
    chk("starve_first_d_gnt", 32'(first), 32'd8);
    nburst = 0;
    stall_bad = 0;
    while (d_gnt && nburst < 10) begin
      nburst++;
      if (c_stall !== 1'b1 || c_gnt !== 1'b0) stall_bad++;
      @(negedge clk);
      #1;
    end
    chk("burst_len", 32'(nburst), 32'd4);
    chk("burst_stall_bad", 32'(stall_bad), 32'd0);
    chk("cpu_regains_gnt", 32'(c_gnt), 32'h1);
    chk("cpu_regains_state", 32'(dut.state_q), 32'(ARB_CPU));
    chk("burst_last_d_rvalid", 32'(d_rvalid), 32'h1);
    chk("burst_last_d_rdata", d_rdata, 32'hFFFFFFFF);
    d_req = 1'b0;
    @(negedge clk);
    #1;
`ifdef ARB_PERF_EN
    chk("perf_forced", 32'(perf_forced), 32'd1);
    chk("perf_d_grant", perf_d_grant, 32'd4);
    chk("perf_c_stall", perf_c_stall, 32'd4);
`endif
    chk("post_burst_starve", 32'(dut.u_ctr.starve_q), 32'd0);

    // Reset coincident with a granted CPU read after starvation credit built up
    c_req = 1'b1; c_we = 4'h0; c_addr = 14'h2000;
    d_req = 1'b1; d_we = 4'h0; d_addr = 14'h3FFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_starve", 32'(dut.u_ctr.starve_q), 32'd3);
    rst = 1'b1;
    #1;
    chk("pre_rst_c_gnt", 32'(c_gnt), 32'h1);
    @(posedge clk);
    #1;
    chk("rst_read_c_rvalid", 32'(c_rvalid), 32'h0);
    chk("rst_read_d_rvalid", 32'(d_rvalid), 32'h0);
    chk("rst_read_state", 32'(dut.state_q), 32'(ARB_CPU));
    chk("rst_read_starve", 32'(dut.u_ctr.starve_q), 32'd0);
    chk("rst_read_burst", 32'(dut.u_ctr.burst_q), 32'd0);
`ifdef ARB_PERF_EN
    chk("rst_perf_c_stall", perf_c_stall, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
